// File: rtl/store_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : store_buffer_pkg
//  Description : Shared depth default, entry layout and width helpers for the
//                posted-write store buffer.
//  Revision    : 1.0  initial release
// ============================================================================
package store_buffer_pkg;

    localparam int SB_DEPTH = 4;

    typedef struct packed {
        logic [29:0] waddr;
        logic [31:0] data;
    } sb_entry_t;

    function automatic int sb_ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    // One extra value is needed so that a completely full buffer is representable.
    function automatic int sb_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/store_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : store_buffer_if
//  Description : Data-memory side of the store buffer: combinational load
//                port plus valid/ready write port.
//  Revision    : 1.0  initial release
// ============================================================================
interface store_buffer_if;

    logic [31:0] mem_raddr;
    logic [31:0] mem_rdata;
    logic        mem_wvalid;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic        mem_wready;

    modport master (
        output mem_raddr,
        input  mem_rdata,
        output mem_wvalid,
        output mem_waddr,
        output mem_wdata,
        input  mem_wready
    );

    modport slave (
        input  mem_raddr,
        output mem_rdata,
        input  mem_wvalid,
        input  mem_waddr,
        input  mem_wdata,
        output mem_wready
    );

endinterface
`default_nettype wire

// File: rtl/store_buffer_match.sv
`default_nettype none
// ============================================================================
//  Module      : store_buffer_match
//  Description : Combinational search for the youngest buffered store whose
//                word address matches the lookup address.
//  Revision    : 1.0  initial release
// ============================================================================
module store_buffer_match
    import store_buffer_pkg::*;
#(
    parameter  int DEPTH = SB_DEPTH,
    localparam int PTR_W = sb_ptr_w(DEPTH),
    localparam int CNT_W = sb_cnt_w(DEPTH)
) (
    input  sb_entry_t          entries [DEPTH],
    input  logic [PTR_W-1:0]   head,
    input  logic [CNT_W-1:0]   count,
    input  logic [29:0]        lookup,
    output logic               hit,
    output logic [31:0]        data
);

    logic [PTR_W-1:0] w_idx;

    // Walk oldest to youngest so the last match found is the youngest one.
    always_comb begin
        hit   = 1'b0;
        data  = '0;
        w_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && (entries[w_idx].waddr == lookup)) begin
                hit  = 1'b1;
                data = entries[w_idx].data;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : store_buffer
//  Description : In-order posted-write FIFO between the processor data port
//                and a handshaked memory, with store-to-load forwarding.
//  Revision    : 1.0  initial release
// ============================================================================
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter  int DEPTH = SB_DEPTH,
    localparam int CNT_W = sb_cnt_w(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cpu_we,
    input  logic [31:0]        cpu_addr,
    input  logic [31:0]        cpu_wdata,
    output logic [31:0]        cpu_rdata,
    output logic               cpu_stall,
    output logic [CNT_W-1:0]   count,
    output logic               empty,
    store_buffer_if.master     mem
);

    localparam int PTR_W = sb_ptr_w(DEPTH);

    sb_entry_t          r_entries [DEPTH];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;

    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic               w_hit;
    logic [31:0]        w_fwd_data;
    logic               w_unused_addr_lsbs;

    // Fullness uses the registered count only, so a same-cycle pop never
    // opens a slot for the store being presented.
    assign w_full = (r_count == CNT_W'(DEPTH));
    assign w_push = cpu_we && !w_full;
    assign w_pop  = (r_count != '0) && mem.mem_wready;

    assign w_unused_addr_lsbs = ^cpu_addr[1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_entries[r_tail] <= '{waddr: cpu_addr[31:2], data: cpu_wdata};
        end
    end

    store_buffer_match #(
        .DEPTH (DEPTH)
    ) u_match (
        .entries (r_entries),
        .head    (r_head),
        .count   (r_count),
        .lookup  (cpu_addr[31:2]),
        .hit     (w_hit),
        .data    (w_fwd_data)
    );

    assign cpu_stall      = cpu_we && w_full;
    assign cpu_rdata      = w_hit ? w_fwd_data : mem.mem_rdata;
    assign count          = r_count;
    assign empty          = (r_count == '0);

    assign mem.mem_raddr  = {cpu_addr[31:2], 2'b00};
    assign mem.mem_wvalid = (r_count != '0);
    assign mem.mem_waddr  = {r_entries[r_head].waddr, 2'b00};
    assign mem.mem_wdata  = r_entries[r_head].data;

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_store_buffer
//  Description : Directed self-checking bench for store_buffer (DEPTH = 4).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_store_buffer;
    import store_buffer_pkg::*;

    localparam int CNT_W = sb_cnt_w(SB_DEPTH);

    logic             clk;
    logic             reset;
    logic             cpu_we;
    logic [31:0]      cpu_addr;
    logic [31:0]      cpu_wdata;
    logic [31:0]      cpu_rdata;
    logic             cpu_stall;
    logic [CNT_W-1:0] count;
    logic             empty;

    store_buffer_if mif ();

    store_buffer #(
        .DEPTH (SB_DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .count     (count),
        .empty     (empty),
        .mem       (mif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        cpu_we    = 1'b1;
        cpu_addr  = addr;
        cpu_wdata = data;
    endtask

    task automatic load(input logic [31:0] addr);
        cpu_we    = 1'b0;
        cpu_addr  = addr;
        cpu_wdata = '0;
    endtask

    initial begin
        reset          = 1'b1;
        cpu_we         = 1'b0;
        cpu_addr       = '0;
        cpu_wdata      = '0;
        mif.mem_rdata  = '0;
        mif.mem_wready = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state, then first store with memory not ready
        store(32'h10, 32'hDEAD_BEEF);
        #1;
        check("rst_count",  32'(count), 32'd0);
        check("rst_empty",  32'(empty), 32'd1);
        check("rst_wvalid", 32'(mif.mem_wvalid), 32'd0);
        check("rst_stall",  32'(cpu_stall), 32'd0);
        check("rst_rdata",  cpu_rdata, 32'h0);
        tick();
        load(32'h10);
        #1;
        check("s1_wvalid", 32'(mif.mem_wvalid), 32'd1);
        check("s1_waddr",  mif.mem_waddr, 32'h10);
        check("s1_wdata",  mif.mem_wdata, 32'hDEAD_BEEF);
        check("s1_count",  32'(count), 32'd1);
        check("s1_fwd",    cpu_rdata, 32'hDEAD_BEEF);
        mif.mem_wready = 1'b1;
        tick();
        mif.mem_wready = 1'b0;
        check("s1_drain", 32'(count), 32'd0);

        // Two stores to one word: youngest forwards, both drain in order
        store(32'h20, 32'd1);
        tick();
        store(32'h20, 32'd2);
        tick();
        load(32'h22);
        mif.mem_rdata = 32'hFFFF_0000;
        #1;
        check("s2_fwd_young", cpu_rdata, 32'd2);
        check("s2_raddr",     mif.mem_raddr, 32'h20);
        check("s2_count",     32'(count), 32'd2);
        mif.mem_wready = 1'b1;
        #1;
        check("s2_wr_first", mif.mem_wdata, 32'd1);
        tick();
        check("s2_wr_second", mif.mem_wdata, 32'd2);
        check("s2_waddr2",    mif.mem_waddr, 32'h20);
        tick();
        mif.mem_wready = 1'b0;
        check("s2_empty", 32'(empty), 32'd1);

        // Fill to DEPTH, fifth store stalls until a slot drains
        for (int k = 0; k < 5; k++) begin
            store(32'h100 + 32'(4 * k), 32'(k));
            #1;
            check("s3_stall", 32'(cpu_stall), (k == 4) ? 32'd1 : 32'd0);
            if (k < 4) tick();
        end
        check("s3_full_count", 32'(count), 32'd4);
        mif.mem_wready = 1'b1;
        tick();
        mif.mem_wready = 1'b0;
        check("s3_after_pop_count", 32'(count), 32'd3);
        check("s3_stall_drop",      32'(cpu_stall), 32'd0);
        tick();
        load(32'h110);
        mif.mem_rdata = 32'h0;
        #1;
        check("s3_refill_count", 32'(count), 32'd4);
        check("s3_head_addr",    mif.mem_waddr, 32'h104);
        check("s3_fwd_wrapped",  cpu_rdata, 32'd4);
        mif.mem_wready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            check("s3_drain_order", mif.mem_wdata, 32'(j + 1));
            tick();
        end
        mif.mem_wready = 1'b0;
        check("s3_drained", 32'(count), 32'd0);

        // Streaming with memory always ready
        mif.mem_wready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            store(32'h200 + 32'(4 * k), 32'h1000 + 32'(k));
            #1;
            check("s4_stall", 32'(cpu_stall), 32'd0);
            if (k > 0) begin
                check("s4_count", 32'(count), 32'd1);
                check("s4_wdata", mif.mem_wdata, 32'h1000 + 32'(k - 1));
                check("s4_waddr", mif.mem_waddr, 32'h200 + 32'(4 * (k - 1)));
            end
            tick();
        end
        load(32'h0);
        #1;
        check("s4_last_count", 32'(count), 32'd1);
        check("s4_last_wdata", mif.mem_wdata, 32'h1009);
        tick();
        mif.mem_wready = 1'b0;
        check("s4_empty", 32'(count), 32'd0);

        // Asynchronous reset while draining is pending
        for (int k = 0; k < 4; k++) begin
            store(32'h300 + 32'(4 * k), 32'h50 + 32'(k));
            tick();
        end
        load(32'h300);
        mif.mem_rdata = 32'h0000_CAFE;
        #1;
        check("s5_pre_fwd",    cpu_rdata, 32'h50);
        check("s5_pre_wvalid", 32'(mif.mem_wvalid), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check("s5_rst_wvalid", 32'(mif.mem_wvalid), 32'd0);
        check("s5_rst_count",  32'(count), 32'd0);
        check("s5_rst_empty",  32'(empty), 32'd1);
        check("s5_rst_rdata",  cpu_rdata, 32'h0000_CAFE);
        cpu_we = 1'b1;
        #1;
        check("s5_rst_stall", 32'(cpu_stall), 32'd0);
        cpu_we = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        check("s5_post_count", 32'(count), 32'd0);

        // Load miss with three entries queued
        for (int k = 0; k < 3; k++) begin
            store(32'h500 + 32'(4 * k), 32'h77 + 32'(k));
            tick();
        end
        load(32'h40);
        mif.mem_rdata = 32'h1234_5678;
        #1;
        check("s6_miss_rdata", cpu_rdata, 32'h1234_5678);
        check("s6_raddr",      mif.mem_raddr, 32'h40);
        check("s6_count",      32'(count), 32'd3);
        load(32'h508);
        #1;
        check("s6_hit_rdata", cpu_rdata, 32'h79);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
